// File: rtl/alu_accumulator.sv
// alu_accumulator: accumulator ALU with clear/load/increment/ALU update and a registered result.
// Define ALU_FLAGS_EN to add the zero (combinational) and carry (registered) flag outputs.
module alu_accumulator #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             RST,
    input  logic [WIDTH-1:0] BusOut,
    input  logic             Wen,
    input  logic             INC,
    input  logic [2:0]       alu_op,
`ifdef ALU_FLAGS_EN
    output logic             zero,
    output logic             carry,
`endif
    output logic [WIDTH-1:0] dout
);
    typedef enum logic [2:0] {
        OP_NOP, OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_NOT
    } op_t;
    logic [WIDTH-1:0] r_ac;
    logic [WIDTH-1:0] w_add;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_mul;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_next;
    op_t              w_op;
    assign w_op  = op_t'(alu_op);
    assign w_add = r_ac + BusOut;
    assign w_sub = r_ac - BusOut;
    always_comb begin
        w_alu = r_ac;
        case (w_op)
            OP_ADD:  w_alu = w_add;
            OP_SUB:  w_alu = w_sub;
            OP_MUL:  w_alu = w_mul;
            OP_AND:  w_alu = r_ac & BusOut;
            OP_OR:   w_alu = r_ac | BusOut;
            OP_XOR:  w_alu = r_ac ^ BusOut;
            OP_NOT:  w_alu = ~r_ac;
            default: w_alu = r_ac;
        endcase
    end
    assign w_next = Wen ? BusOut : INC ? r_ac + WIDTH'(1) : w_alu;
    always_ff @(posedge Clk) begin
        if (RST) r_ac <= '0;
        else     r_ac <= w_next;
    end
    assign dout = r_ac;
`ifdef ALU_FLAGS_EN
    logic [WIDTH-1:0] w_mul_hi;
    logic             w_alu_c;
    logic             w_next_c;
    logic             r_carry;
    // Full-width product so discarded high bits can raise carry.
    assign {w_mul_hi, w_mul} = {{WIDTH{1'b0}}, r_ac} * {{WIDTH{1'b0}}, BusOut};
    always_comb begin
        w_alu_c = 1'b0;
        case (w_op)
            OP_NOP:  w_alu_c = r_carry;
            OP_ADD:  w_alu_c = w_add < r_ac;
            OP_SUB:  w_alu_c = r_ac < BusOut;
            OP_MUL:  w_alu_c = |w_mul_hi;
            default: w_alu_c = 1'b0;
        endcase
    end
    assign w_next_c = Wen ? 1'b0 : INC ? (r_ac == '1) : w_alu_c;
    always_ff @(posedge Clk) begin
        if (RST) r_carry <= 1'b0;
        else     r_carry <= w_next_c;
    end
    assign zero  = (r_ac == '0);
    assign carry = r_carry;
`else
    assign w_mul = r_ac * BusOut;
`endif
endmodule

// File: tb/tb_alu_accumulator.sv
// tb_alu_accumulator: directed vectors plus a randomized scoreboard run for alu_accumulator.
// Flag outputs are checked too when ALU_FLAGS_EN is defined.
module tb_alu_accumulator;
    logic       Clk = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] BusOut = '0;
    logic       Wen = 1'b0;
    logic       INC = 1'b0;
    logic [2:0] alu_op = '0;
    logic [7:0] dout;
`ifdef ALU_FLAGS_EN
    logic       zero;
    logic       carry;
`endif
    int total = 0;
    int bad = 0;

    alu_accumulator #(.WIDTH(8)) dut (
        .Clk(Clk),
        .RST(RST),
        .BusOut(BusOut),
        .Wen(Wen),
        .INC(INC),
        .alu_op(alu_op),
`ifdef ALU_FLAGS_EN
        .zero(zero),
        .carry(carry),
`endif
        .dout(dout)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic wen, input logic inc,
                        input logic [2:0] op, input logic [7:0] bus);
        RST = rst;
        Wen = wen;
        INC = inc;
        alu_op = op;
        BusOut = bus;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_c(input string tag, input logic exp_c);
`ifdef ALU_FLAGS_EN
        chk(tag, {31'd0, carry}, {31'd0, exp_c});
        chk({tag, "_z"}, {31'd0, zero}, {31'd0, dout == 8'h00});
`endif
    endtask

    function automatic logic [8:0] model(input logic [7:0] ac, input logic c, input logic rst,
                                         input logic wen, input logic inc, input logic [2:0] op,
                                         input logic [7:0] bus);
        int unsigned r;
        if (rst) return 9'd0;
        if (wen) return {1'b0, bus};
        if (inc) return {ac == 8'hFF, ac + 8'd1};
        case (op)
            3'd1: begin r = ac + bus; return {r > 255, r[7:0]}; end
            3'd2: return {ac < bus, ac - bus};
            3'd3: begin r = ac * bus; return {r > 255, r[7:0]}; end
            3'd4: return {1'b0, ac & bus};
            3'd5: return {1'b0, ac | bus};
            3'd6: return {1'b0, ac ^ bus};
            3'd7: return {1'b0, ~ac};
            default: return {c, ac};
        endcase
    endfunction

    initial begin
        logic [7:0] m_ac;
        logic       m_c;
        logic [8:0] m;
        logic       r_rst, r_wen, r_inc;
        logic [2:0] r_op;
        logic [7:0] r_bus;
        #2;
        step(1, 0, 0, 3'd0, 8'h00); chk("reset", dout, 8'h00); chk_c("reset_c", 1'b0);
        step(0, 1, 0, 3'd0, 8'd35); chk("load35", dout, 8'd35);
        step(0, 0, 0, 3'd0, 8'd45); chk("hold", dout, 8'd35);
        step(0, 0, 1, 3'd0, 8'd0);  chk("inc1", dout, 8'd36);
        step(0, 0, 1, 3'd0, 8'd0);  chk("inc2", dout, 8'd37);
        step(1, 0, 0, 3'd0, 8'd0);  chk("rst_mid", dout, 8'd0);
        step(0, 1, 0, 3'd0, 8'hFF); chk("loadff", dout, 8'hFF);
        step(0, 0, 1, 3'd0, 8'h00); chk("inc_wrap", dout, 8'h00); chk_c("inc_wrap_c", 1'b1);
        step(0, 1, 0, 3'd0, 8'd12); chk("load12", dout, 8'd12); chk_c("load_c", 1'b0);
        step(0, 0, 0, 3'd1, 8'd13); chk("add13", dout, 8'd25);
        step(0, 0, 0, 3'd2, 8'd3);  chk("sub3a", dout, 8'd22);
        step(0, 0, 0, 3'd2, 8'd3);  chk("sub3b", dout, 8'd19);
        step(0, 0, 0, 3'd3, 8'd5);  chk("mul5", dout, 8'd95); chk_c("mul5_c", 1'b0);
        step(0, 0, 0, 3'd4, 8'd6);  chk("and6", dout, 8'd6);
        step(0, 1, 0, 3'd0, 8'h10);
        step(0, 0, 0, 3'd2, 8'h20); chk("sub_wrap", dout, 8'hF0); chk_c("sub_wrap_c", 1'b1);
        step(0, 0, 0, 3'd0, 8'h77); chk("nop_hold", dout, 8'hF0); chk_c("nop_hold_c", 1'b1);
        step(0, 1, 0, 3'd0, 8'h20);
        step(0, 0, 0, 3'd3, 8'h10); chk("mul_wrap", dout, 8'h00); chk_c("mul_wrap_c", 1'b1);
        step(0, 1, 0, 3'd0, 8'hC8);
        step(0, 0, 0, 3'd1, 8'h64); chk("add_wrap", dout, 8'h2C); chk_c("add_wrap_c", 1'b1);
        step(0, 1, 0, 3'd0, 8'h0F);
        step(0, 0, 0, 3'd5, 8'hF0); chk("or", dout, 8'hFF);
        step(0, 0, 0, 3'd6, 8'h3C); chk("xor", dout, 8'hC3);
        step(0, 0, 0, 3'd7, 8'hFF); chk("not", dout, 8'h3C); chk_c("not_c", 1'b0);
        step(1, 1, 0, 3'd0, 8'hAA); chk("pri_rst_wen", dout, 8'h00);
        step(0, 1, 1, 3'd1, 8'h55); chk("pri_wen_inc", dout, 8'h55);
        step(0, 0, 1, 3'd1, 8'h10); chk("pri_inc_alu", dout, 8'h56);
        m_ac = 8'h56;
        m_c = 1'b0;
        for (int i = 0; i < 60; i++) begin
            r_rst = ($urandom_range(0, 15) == 0);
            r_wen = ($urandom_range(0, 5) == 0);
            r_inc = ($urandom_range(0, 5) == 0);
            r_op  = 3'($urandom_range(0, 7));
            r_bus = 8'($urandom_range(0, 255));
            m = model(m_ac, m_c, r_rst, r_wen, r_inc, r_op, r_bus);
            {m_c, m_ac} = m;
            step(r_rst, r_wen, r_inc, r_op, r_bus);
            chk("rand", dout, m_ac);
            chk_c("rand_c", m_c);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
